// File: rtl/kinase_seq_pkg.sv
// -----------------------------------------------------------------------------
// kinase_seq_pkg
// Shared definitions for the kinase actuation sequencer: FSM state encoding,
// pump-select encodings, pad-bundle widths and the six-step peristaltic
// drive patterns for pump_a (3 valves) and pump_b (2 valves).
// Optional feature macro used by the top level: KINASE_SEQ_ABORT_EN.
// -----------------------------------------------------------------------------
package kinase_seq_pkg;

    localparam int CTRL_A_W = 13;
    localparam int CTRL_S_W = 4;
    localparam int PUMP_A_W = 3;
    localparam int PUMP_B_W = 2;
    localparam int PHASES   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PUMP,
        ST_DWELL,
        ST_DONE
    } seq_state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_BOTH = 2'b11;

    // Step 0 lives in the least significant slice.
    localparam logic [PHASES*PUMP_A_W-1:0] PUMP_A_PAT =
        {3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
    localparam logic [PHASES*PUMP_B_W-1:0] PUMP_B_PAT =
        {2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    function automatic logic [PUMP_A_W-1:0] pump_a_at(input logic [2:0] phase);
        logic [PUMP_A_W-1:0] pat;
        pat = '0;
        for (int i = 0; i < PHASES; i++) begin
            if (int'(phase) == i) pat = PUMP_A_PAT[i*PUMP_A_W +: PUMP_A_W];
        end
        return pat;
    endfunction

    function automatic logic [PUMP_B_W-1:0] pump_b_at(input logic [2:0] phase);
        logic [PUMP_B_W-1:0] pat;
        pat = '0;
        for (int i = 0; i < PHASES; i++) begin
            if (int'(phase) == i) pat = PUMP_B_PAT[i*PUMP_B_W +: PUMP_B_W];
        end
        return pat;
    endfunction

endpackage

// File: rtl/kinase_pump_phase_gen.sv
// -----------------------------------------------------------------------------
// kinase_pump_phase_gen
// Runs the peristaltic pumps for a given number of full 6-step cycles.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_start       one-cycle pulse: begin at step 0 on the next edge
//   i_stop        abandon the run; pumps go to 0 on the next edge
//   i_sel         pump select (held stable by the caller during the run)
//   i_cycles      number of full cycles, 1..255 (held stable during the run)
//   o_pump_a      3-valve drive, 0 when idle or unselected
//   o_pump_b      2-valve drive, 0 when idle or unselected
//   o_finished    high during the last clock of the run; pumps are 0 after
//                 the edge that ends that clock
// -----------------------------------------------------------------------------
module kinase_pump_phase_gen
    import kinase_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [1:0]          i_sel,
    input  logic [7:0]          i_cycles,
    output logic [PUMP_A_W-1:0] o_pump_a,
    output logic [PUMP_B_W-1:0] o_pump_b,
    output logic                o_finished
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic              r_run;
    logic [STEP_W-1:0] r_step_cnt;
    logic [2:0]        r_phase;
    logic [7:0]        r_cyc_cnt;

    logic w_step_last;
    logic w_phase_last;
    logic w_cyc_last;

    assign w_step_last  = (r_step_cnt == STEP_W'(STEP_CYCLES - 1));
    assign w_phase_last = (r_phase == 3'(PHASES - 1));
    // Counts 0..cycles-1, so the 8-bit counter never wraps even at 255.
    assign w_cyc_last   = (r_cyc_cnt == (i_cycles - 8'd1));
    assign o_finished   = r_run && w_step_last && w_phase_last && w_cyc_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run      <= 1'b0;
            r_step_cnt <= '0;
            r_phase    <= '0;
            r_cyc_cnt  <= '0;
        end else if (i_stop) begin
            r_run <= 1'b0;
        end else if (i_start) begin
            r_run      <= 1'b1;
            r_step_cnt <= '0;
            r_phase    <= '0;
            r_cyc_cnt  <= '0;
        end else if (r_run) begin
            if (w_step_last) begin
                r_step_cnt <= '0;
                if (w_phase_last) begin
                    r_phase <= '0;
                    if (w_cyc_last) r_run <= 1'b0;
                    else            r_cyc_cnt <= r_cyc_cnt + 8'd1;
                end else begin
                    r_phase <= r_phase + 3'd1;
                end
            end else begin
                r_step_cnt <= r_step_cnt + STEP_W'(1);
            end
        end
    end

    assign o_pump_a = (r_run && i_sel[0]) ? pump_a_at(r_phase) : '0;
    assign o_pump_b = (r_run && i_sel[1]) ? pump_b_at(r_phase) : '0;

endmodule

// File: rtl/kinase_actuation_sequencer.sv
// -----------------------------------------------------------------------------
// kinase_actuation_sequencer
// Drives the kinase_activity chip control pads. Per accepted command: apply
// the valve pattern, settle, pump N full cycles, dwell, pulse done.
// Optional feature macro: KINASE_SEQ_ABORT_EN (adds the abort input).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   abort             (KINASE_SEQ_ABORT_EN only) stop the active command
//   cmd_valid/ready   command handshake; ready only in IDLE
//   cmd_ctrl_a/s      valve patterns
//   cmd_pump_sel      00 none, 01 pump_a, 10 pump_b, 11 both
//   cmd_pump_cycles   full pump cycles to run
//   cmd_dwell         clocks to dwell after pumping
//   ctrl_a, ctrl_s    registered valve drive, held after completion
//   pump_a, pump_b    peristaltic drive
//   busy              FSM not in IDLE
//   done              one-cycle completion pulse
// -----------------------------------------------------------------------------
module kinase_actuation_sequencer
    import kinase_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000,
    parameter int STEP_CYCLES   = 500,
    parameter int DWELL_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
`ifdef KINASE_SEQ_ABORT_EN
    input  logic                abort,
`endif
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CTRL_A_W-1:0] cmd_ctrl_a,
    input  logic [CTRL_S_W-1:0] cmd_ctrl_s,
    input  logic [1:0]          cmd_pump_sel,
    input  logic [7:0]          cmd_pump_cycles,
    input  logic [DWELL_W-1:0]  cmd_dwell,
    output logic [CTRL_A_W-1:0] ctrl_a,
    output logic [CTRL_S_W-1:0] ctrl_s,
    output logic [PUMP_A_W-1:0] pump_a,
    output logic [PUMP_B_W-1:0] pump_b,
    output logic                busy,
    output logic                done
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_sel;
    logic [7:0]          r_cycles;
    logic [DWELL_W-1:0]  r_dwell;
    logic [CTRL_A_W-1:0] r_ctrl_a;
    logic [CTRL_S_W-1:0] r_ctrl_s;

    logic w_accept;
    logic w_start;
    logic w_abort_hit;
    logic w_finished;
    logic w_pump_needed;
    logic w_dwell_zero;
    logic w_settle_last;
    logic w_dwell_last;
    logic w_abort_in;

`ifdef KINASE_SEQ_ABORT_EN
    assign w_abort_in = abort;
`else
    assign w_abort_in = 1'b0;
`endif

    // All decisions use the latched command fields.
    assign w_pump_needed = (r_sel != SEL_NONE) && (r_cycles != 8'd0);
    assign w_dwell_zero  = (r_dwell == '0);
    assign w_settle_last = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign w_dwell_last  = (r_cnt == (CNT_W'(r_dwell) - CNT_W'(1)));
    assign w_accept      = (r_state == ST_IDLE) && cmd_valid;
    assign w_abort_hit   = w_abort_in &&
                           ((r_state == ST_SETTLE) || (r_state == ST_PUMP) ||
                            (r_state == ST_DWELL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        cmd_ready = 1'b0;
        busy      = (r_state != ST_IDLE);
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_abort_hit) begin
                    w_next = ST_DONE;
                end else if (w_settle_last) begin
                    if (w_pump_needed) begin
                        w_next  = ST_PUMP;
                        w_start = 1'b1;
                    end else begin
                        w_next = w_dwell_zero ? ST_DONE : ST_DWELL;
                    end
                end
            end
            ST_PUMP: begin
                if (w_abort_hit)     w_next = ST_DONE;
                else if (w_finished) w_next = w_dwell_zero ? ST_DONE : ST_DWELL;
            end
            ST_DWELL: begin
                if (w_abort_hit || w_dwell_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Shared settle/dwell counter, cleared on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != w_next) begin
            r_cnt <= '0;
        end else if ((r_state == ST_SETTLE) || (r_state == ST_DWELL)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel    <= '0;
            r_cycles <= '0;
            r_dwell  <= '0;
            r_ctrl_a <= '0;
            r_ctrl_s <= '0;
        end else if (w_accept) begin
            r_sel    <= cmd_pump_sel;
            r_cycles <= cmd_pump_cycles;
            r_dwell  <= cmd_dwell;
            r_ctrl_a <= cmd_ctrl_a;
            r_ctrl_s <= cmd_ctrl_s;
        end else if (w_abort_hit) begin
            r_ctrl_a <= '0;
            r_ctrl_s <= '0;
        end
    end

    assign ctrl_a = r_ctrl_a;
    assign ctrl_s = r_ctrl_s;

    kinase_pump_phase_gen #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_phase_gen (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_stop     (w_abort_hit),
        .i_sel      (r_sel),
        .i_cycles   (r_cycles),
        .o_pump_a   (pump_a),
        .o_pump_b   (pump_b),
        .o_finished (w_finished)
    );

endmodule

// File: tb/tb_kinase_actuation_sequencer.sv
module tb_kinase_actuation_sequencer;

    localparam int SETTLE = 4;
    localparam int STEP   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
`ifdef KINASE_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [12:0] cmd_ctrl_a = '0;
    logic [3:0]  cmd_ctrl_s = '0;
    logic [1:0]  cmd_pump_sel = '0;
    logic [7:0]  cmd_pump_cycles = '0;
    logic [15:0] cmd_dwell = '0;
    logic [12:0] ctrl_a;
    logic [3:0]  ctrl_s;
    logic [2:0]  pump_a;
    logic [1:0]  pump_b;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] pa_tab [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    logic [1:0] pb_tab [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

    kinase_actuation_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .STEP_CYCLES  (STEP),
        .DWELL_W      (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef KINASE_SEQ_ABORT_EN
        .abort           (abort),
`endif
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_ctrl_a      (cmd_ctrl_a),
        .cmd_ctrl_s      (cmd_ctrl_s),
        .cmd_pump_sel    (cmd_pump_sel),
        .cmd_pump_cycles (cmd_pump_cycles),
        .cmd_dwell       (cmd_dwell),
        .ctrl_a          (ctrl_a),
        .ctrl_s          (ctrl_s),
        .pump_a          (pump_a),
        .pump_b          (pump_b),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [12:0] ea, input logic [3:0] es,
                             input logic [2:0] epa, input logic [1:0] epb,
                             input logic eready, input logic ebusy, input logic edone);
        check({tag, " ctrl_a"}, 32'(ctrl_a), 32'(ea));
        check({tag, " ctrl_s"}, 32'(ctrl_s), 32'(es));
        check({tag, " pump_a"}, 32'(pump_a), 32'(epa));
        check({tag, " pump_b"}, 32'(pump_b), 32'(epb));
        check({tag, " ready"},  32'(cmd_ready), 32'(eready));
        check({tag, " busy"},   32'(busy), 32'(ebusy));
        check({tag, " done"},   32'(done), 32'(edone));
    endtask

    task automatic idle_cycles(input int n, input logic [12:0] ea, input logic [3:0] es);
        for (int i = 0; i < n; i++) begin
            tick();
            check_all($sformatf("idle%0d", i), ea, es, 3'b0, 2'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Offers a command in the current IDLE cycle and checks every cycle
    // through the first IDLE cycle after done. With hold_next, a second
    // command is offered from the 6th busy cycle onward and left on the bus.
    task automatic run_cmd(input logic [12:0] a, input logic [3:0] s, input logic [1:0] sel,
                           input logic [7:0] cyc, input logic [15:0] dw,
                           input bit hold_next, input logic [12:0] na, input logic [3:0] ns,
                           input logic [1:0] nsel, input logic [7:0] ncyc, input logic [15:0] ndw);
        int n_eff, p_start, p_end, done_k, ph;
        logic [2:0] epa;
        logic [1:0] epb;
        n_eff   = (sel != 2'b00 && cyc != 8'd0) ? int'(cyc) : 0;
        p_start = 1 + SETTLE;
        p_end   = p_start + 6 * STEP * n_eff;
        done_k  = p_end + int'(dw);
        cmd_ctrl_a = a; cmd_ctrl_s = s; cmd_pump_sel = sel;
        cmd_pump_cycles = cyc; cmd_dwell = dw; cmd_valid = 1'b1;
        tick();
        // Scramble the bus: the latched fields must govern the run.
        cmd_valid = 1'b0;
        cmd_ctrl_a = ~a; cmd_ctrl_s = ~s; cmd_pump_sel = ~sel;
        cmd_pump_cycles = cyc + 8'd3; cmd_dwell = dw + 16'd7;
        for (int k = 1; k <= done_k + 1; k++) begin
            if (hold_next && k == 6) begin
                cmd_ctrl_a = na; cmd_ctrl_s = ns; cmd_pump_sel = nsel;
                cmd_pump_cycles = ncyc; cmd_dwell = ndw; cmd_valid = 1'b1;
            end
            epa = 3'b0;
            epb = 2'b0;
            if (k >= p_start && k < p_end) begin
                ph = ((k - p_start) / STEP) % 6;
                if (sel[0]) epa = pa_tab[ph];
                if (sel[1]) epb = pb_tab[ph];
            end
            check_all($sformatf("cmd%03x k%0d", a, k), a, s, epa, epb,
                      k > done_k, k <= done_k, k == done_k);
            if (k <= done_k) tick();
        end
    endtask

    initial begin
        // Reset held from time 0
        repeat (2) @(posedge clk);
        #1;
        check_all("rst", 13'h0, 4'h0, 3'b0, 2'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        idle_cycles(10, 13'h0, 4'h0);

        run_cmd(13'h1A5, 4'h3, 2'b01, 8'd2, 16'd3, 1'b0, '0, '0, '0, '0, '0);
        run_cmd(13'h0F0, 4'hA, 2'b00, 8'd5, 16'd0, 1'b0, '0, '0, '0, '0, '0);
        run_cmd(13'h1FFF, 4'hF, 2'b11, 8'd0, 16'd0, 1'b0, '0, '0, '0, '0, '0);
        run_cmd(13'h055, 4'h5, 2'b11, 8'd1, 16'd2, 1'b1, 13'h0AA, 4'h6, 2'b10, 8'd1, 16'd0);
        run_cmd(13'h0AA, 4'h6, 2'b10, 8'd1, 16'd0, 1'b0, '0, '0, '0, '0, '0);
        run_cmd(13'h111, 4'h9, 2'b01, 8'd1, 16'd1, 1'b0, '0, '0, '0, '0, '0);
        idle_cycles(3, 13'h111, 4'h9);

        // Asynchronous reset in the middle of a pump run
        cmd_ctrl_a = 13'h123; cmd_ctrl_s = 4'h1; cmd_pump_sel = 2'b01;
        cmd_pump_cycles = 8'd3; cmd_dwell = 16'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (6) tick();
        check("midrst pre pump_a", 32'(pump_a), 32'(3'b110));
        #3 rst = 1'b1;
        #1;
        check_all("midrst", 13'h0, 4'h0, 3'b0, 2'b0, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        idle_cycles(10, 13'h0, 4'h0);

`ifdef KINASE_SEQ_ABORT_EN
        // Abort on the 3rd PUMP clock
        cmd_ctrl_a = 13'h1A5; cmd_ctrl_s = 4'h3; cmd_pump_sel = 2'b01;
        cmd_pump_cycles = 8'd2; cmd_dwell = 16'd3; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (6) tick();
        check("abort pre pump_a", 32'(pump_a), 32'(3'b110));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_all("abort done", 13'h0, 4'h0, 3'b0, 2'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_all("abort idle", 13'h0, 4'h0, 3'b0, 2'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of DWELL: no done pulse
        cmd_ctrl_a = 13'h0C3; cmd_ctrl_s = 4'h7; cmd_pump_sel = 2'b00;
        cmd_pump_cycles = 8'd0; cmd_dwell = 16'd5; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (6) tick();
        check("dwell pre busy", 32'(busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        check_all("dwellrst", 13'h0, 4'h0, 3'b0, 2'b0, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        idle_cycles(6, 13'h0, 4'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
